// File: rtl/game_flow_pkg.sv
// Shared types and defaults for the game flow sequencer and its second-based timers.
package game_flow_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        ARM       = 3'd1,
        PLAY      = 3'd2,
        RESULT    = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5,
        PAUSE     = 3'd6
    } game_state_t;

    localparam int DEFAULT_CLK_FREQ_HZ = 25_000_000;

endpackage

// File: rtl/game_flow_controller_tick_gen.sv
// Free-running one-second tick: counts 0..CLK_FREQ_HZ-1, tick at the terminal count.
module tick_gen
    import game_flow_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic freeze,
    output logic tick
);

    localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!freeze)
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end

    // A frozen counter parked on TERM must not keep firing.
    assign tick = (cnt == TERM) && !freeze;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer driving the level controller and the overlay selects.
// Optional pause support is compiled in with `define GAME_FLOW_PAUSE_EN.
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
    parameter int RESULT_HOLD_SEC = 3,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startKey,
`ifdef GAME_FLOW_PAUSE_EN
    input  logic       pauseKey,
`endif
    input  logic       startOfFrame,
    input  logic       stageEnded,
    input  logic       stageFailed,
    input  logic       lastLevelEnded,
    output logic       levelEnable,
    output logic       cycleLevel,
    output logic       oneSecPulse,
    output logic       titleScreenEn,
    output logic       resultScreenEn,
    output logic       gameOverScreenEn,
    output logic       winScreenEn,
    output logic [2:0] stateCode
);

    localparam int HW = (RESULT_HOLD_SEC > 1) ? $clog2(RESULT_HOLD_SEC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_HOLD_SEC - 1);

    game_state_t state, next_state;

    logic [SYNC_STAGES-1:0] start_sync;
    logic                   start_d;
    logic                   key_rise;
    logic                   tick;
    logic                   tick_clear;
    logic                   tick_freeze;
    logic [HW-1:0]          hold_cnt;
    logic                   from_result;
    logic                   cycle_q;
    logic                   pulse_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_sync <= '0;
            start_d    <= 1'b0;
        end else begin
            start_sync <= (start_sync << 1) | SYNC_STAGES'(startKey);
            start_d    <= start_sync[SYNC_STAGES-1];
        end
    end

    assign key_rise = start_sync[SYNC_STAGES-1] & ~start_d;

`ifdef GAME_FLOW_PAUSE_EN
    logic [SYNC_STAGES-1:0] pause_sync;
    logic                   pause_d;
    logic                   pause_rise;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pause_sync <= '0;
            pause_d    <= 1'b0;
        end else begin
            pause_sync <= (pause_sync << 1) | SYNC_STAGES'(pauseKey);
            pause_d    <= pause_sync[SYNC_STAGES-1];
        end
    end

    assign pause_rise  = pause_sync[SYNC_STAGES-1] & ~pause_d;
    assign tick_freeze = (state == PAUSE);
`else
    assign tick_freeze = 1'b0;
`endif

    // Restart the second count on PLAY entry from ARM (not on unpause) and on RESULT entry.
    assign tick_clear = (state == ARM && next_state == PLAY) ||
                        (state != RESULT && next_state == RESULT);

    tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .resetN (resetN),
        .clear  (tick_clear),
        .freeze (tick_freeze),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= TITLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TITLE:     if (key_rise) next_state = ARM;
            ARM:       if (startOfFrame) next_state = PLAY;
            PLAY: begin
                if (stageFailed)                         next_state = GAME_OVER;
                else if (stageEnded && lastLevelEnded)   next_state = WIN;
                else if (stageEnded)                     next_state = RESULT;
`ifdef GAME_FLOW_PAUSE_EN
                else if (pause_rise)                     next_state = PAUSE;
`endif
            end
`ifdef GAME_FLOW_PAUSE_EN
            PAUSE:     if (pause_rise) next_state = PLAY;
`endif
            RESULT:    if (key_rise || (tick && hold_cnt == HOLD_LAST)) next_state = ARM;
            GAME_OVER: if (key_rise) next_state = TITLE;
            WIN:       if (key_rise) next_state = TITLE;
            default:   next_state = TITLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_cnt    <= '0;
            from_result <= 1'b0;
            cycle_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            if (state != RESULT)
                hold_cnt <= '0;
            else if (tick)
                hold_cnt <= hold_cnt + 1'b1;
            if (next_state == ARM && state != ARM)
                from_result <= (state == RESULT);
            cycle_q <= (state == PLAY) && (next_state == RESULT);
            pulse_q <= tick && (state == PLAY);
        end
    end

    always_comb begin
        levelEnable      = (state == PLAY) || (state == PAUSE);
        cycleLevel       = cycle_q;
        oneSecPulse      = pulse_q;
        titleScreenEn    = (state == TITLE);
        resultScreenEn   = (state == RESULT) || (state == ARM && from_result);
        gameOverScreenEn = (state == GAME_OVER);
        winScreenEn      = (state == WIN);
        stateCode        = state;
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller (CLK_FREQ_HZ=10, RESULT_HOLD_SEC=3).
module tb_game_flow_controller;

    localparam logic [2:0] S_TITLE = 3'd0, S_ARM = 3'd1, S_PLAY = 3'd2, S_RESULT = 3'd3,
                           S_GO = 3'd4, S_WIN = 3'd5, S_PAUSE = 3'd6;
    localparam logic [3:0] OV_T = 4'b1000, OV_R = 4'b0100, OV_G = 4'b0010,
                           OV_W = 4'b0001, OV_N = 4'b0000;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startKey = 1'b0, startOfFrame = 1'b0, stageEnded = 1'b0;
    logic       stageFailed = 1'b0, lastLevelEnded = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
    logic       pauseKey = 1'b0;
`endif
    logic       levelEnable, cycleLevel, oneSecPulse;
    logic       titleScreenEn, resultScreenEn, gameOverScreenEn, winScreenEn;
    logic [2:0] stateCode;

    int tests = 0;
    int fails = 0;

    game_flow_controller #(
        .CLK_FREQ_HZ     (10),
        .RESULT_HOLD_SEC (3),
        .SYNC_STAGES     (2)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startKey         (startKey),
`ifdef GAME_FLOW_PAUSE_EN
        .pauseKey         (pauseKey),
`endif
        .startOfFrame     (startOfFrame),
        .stageEnded       (stageEnded),
        .stageFailed      (stageFailed),
        .lastLevelEnded   (lastLevelEnded),
        .levelEnable      (levelEnable),
        .cycleLevel       (cycleLevel),
        .oneSecPulse      (oneSecPulse),
        .titleScreenEn    (titleScreenEn),
        .resultScreenEn   (resultScreenEn),
        .gameOverScreenEn (gameOverScreenEn),
        .winScreenEn      (winScreenEn),
        .stateCode        (stateCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       key, sof, se, sf, lle;
        logic [2:0] st;
        logic       le, cl;
        logic [3:0] ov;
    } vec_t;

    vec_t vt[35];

    function automatic vec_t mk(input logic key, sof, se, sf, lle,
                                input logic [2:0] st, input logic le, cl,
                                input logic [3:0] ov);
        vec_t v;
        v.key = key; v.sof = sof; v.se = se; v.sf = sf; v.lle = lle;
        v.st = st; v.le = le; v.cl = cl; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        startKey = 0; startOfFrame = 0; stageEnded = 0; stageFailed = 0; lastLevelEnded = 0;
`ifdef GAME_FLOW_PAUSE_EN
        pauseKey = 0;
`endif
        resetN = 0;
        step();
        step();
        resetN = 1;
        step();
    endtask

    // Press start from TITLE, then issue a frame start; ends just after PLAY entry.
    task automatic go_play();
        startKey = 1;
        for (int c = 0; c < 10 && stateCode != S_ARM; c++) step();
        startKey = 0;
        chk("go_play_arm", stateCode, S_ARM);
        startOfFrame = 1;
        step();
        startOfFrame = 0;
        chk("go_play_play", stateCode, S_PLAY);
    endtask

    initial begin
        int arms, le_early, pulse_seen;
        logic [2:0] prev;

        vt[0]  = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[1]  = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[2]  = mk(1,0,0,0,0, S_ARM,   0,0, OV_N);
        vt[3]  = mk(1,0,0,0,0, S_ARM,   0,0, OV_N);
        vt[4]  = mk(0,1,0,0,0, S_PLAY,  1,0, OV_N);
        vt[5]  = mk(0,0,1,0,0, S_RESULT,0,1, OV_R);
        vt[6]  = mk(0,0,0,0,0, S_RESULT,0,0, OV_R);
        vt[7]  = mk(1,0,0,0,0, S_RESULT,0,0, OV_R);
        vt[8]  = mk(1,0,0,0,0, S_RESULT,0,0, OV_R);
        vt[9]  = mk(0,0,0,0,0, S_ARM,   0,0, OV_R);
        vt[10] = mk(0,1,0,0,0, S_PLAY,  1,0, OV_N);
        vt[11] = mk(0,0,1,1,1, S_GO,    0,0, OV_G);
        vt[12] = mk(0,0,0,0,0, S_GO,    0,0, OV_G);
        vt[13] = mk(1,0,0,0,0, S_GO,    0,0, OV_G);
        vt[14] = mk(1,0,0,0,0, S_GO,    0,0, OV_G);
        vt[15] = mk(0,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[16] = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[17] = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[18] = mk(0,0,0,0,0, S_ARM,   0,0, OV_N);
        vt[19] = mk(0,1,0,0,0, S_PLAY,  1,0, OV_N);
        vt[20] = mk(0,0,1,0,1, S_WIN,   0,0, OV_W);
        vt[21] = mk(0,0,0,0,0, S_WIN,   0,0, OV_W);
        vt[22] = mk(1,0,0,0,0, S_WIN,   0,0, OV_W);
        vt[23] = mk(1,0,0,0,0, S_WIN,   0,0, OV_W);
        vt[24] = mk(0,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[25] = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[26] = mk(1,0,0,0,0, S_TITLE, 0,0, OV_T);
        vt[27] = mk(1,0,0,0,0, S_ARM,   0,0, OV_N);
        vt[28] = mk(1,1,0,0,0, S_PLAY,  1,0, OV_N);
        vt[29] = mk(0,0,0,0,0, S_PLAY,  1,0, OV_N);
        vt[30] = mk(1,0,0,0,0, S_PLAY,  1,0, OV_N);
        vt[31] = mk(1,0,0,0,0, S_PLAY,  1,0, OV_N);
        vt[32] = mk(1,0,0,0,0, S_PLAY,  1,0, OV_N);
        vt[33] = mk(0,0,1,0,0, S_RESULT,0,1, OV_R);
        vt[34] = mk(0,0,0,1,0, S_RESULT,0,0, OV_R);

        // Reset state
        resetN = 0;
        step();
        chk("rst_state", stateCode, S_TITLE);
        chk("rst_overlays", {titleScreenEn, resultScreenEn, gameOverScreenEn, winScreenEn}, OV_T);
        chk("rst_outs", {levelEnable, cycleLevel, oneSecPulse}, 3'b000);
        resetN = 1;
        step();

        // Table-driven flow
        for (int i = 0; i < 35; i++) begin
            startKey = vt[i].key; startOfFrame = vt[i].sof; stageEnded = vt[i].se;
            stageFailed = vt[i].sf; lastLevelEnded = vt[i].lle;
            step();
            chk($sformatf("vec%0d_state", i), stateCode, vt[i].st);
            chk($sformatf("vec%0d_le", i), levelEnable, vt[i].le);
            chk($sformatf("vec%0d_cl", i), cycleLevel, vt[i].cl);
            chk($sformatf("vec%0d_ov", i),
                {titleScreenEn, resultScreenEn, gameOverScreenEn, winScreenEn}, vt[i].ov);
        end
        startKey = 0; startOfFrame = 0; stageEnded = 0; stageFailed = 0; lastLevelEnded = 0;

        // Held key: one ARM transition; levelEnable only after the frame start
        do_reset();
        arms = 0; le_early = 0;
        startKey = 1;
        for (int c = 0; c < 30; c++) begin
            prev = stateCode;
            step();
            if (prev == S_TITLE && stateCode == S_ARM) arms++;
            if (levelEnable) le_early++;
            if (c == 19) startKey = 0;
        end
        chk("held_key_arms", arms, 1);
        chk("le_before_sof", le_early, 0);
        startOfFrame = 1;
        step();
        startOfFrame = 0;
        chk("le_after_sof", levelEnable, 1);

        // oneSecPulse cadence from PLAY entry
        do_reset();
        go_play();
        for (int k = 1; k <= 35; k++) begin
            step();
            chk($sformatf("pulse_k%0d", k), oneSecPulse, (k % 10 == 0) ? 1 : 0);
        end

        // RESULT hold of three seconds, then frame-aligned restart
        stageEnded = 1;
        step();
        stageEnded = 0;
        chk("res_cl", cycleLevel, 1);
        chk("res_le", levelEnable, 0);
        chk("res_ov", resultScreenEn, 1);
        step();
        chk("res_cl_drop", cycleLevel, 0);
        for (int k = 2; k <= 30; k++) begin
            step();
            if (k == 29) chk("res_hold29", stateCode, S_RESULT);
            if (k == 30) chk("res_arm30", stateCode, S_ARM);
        end
        chk("arm_res_ov", resultScreenEn, 1);
        step();
        step();
        chk("arm_wait", stateCode, S_ARM);
        startOfFrame = 1;
        step();
        startOfFrame = 0;
        chk("replay_state", stateCode, S_PLAY);
        chk("replay_ov", resultScreenEn, 0);
        chk("replay_le", levelEnable, 1);

        // Asynchronous reset mid-PLAY
        repeat (7) step();
        #3;
        resetN = 0;
        #1;
        chk("async_le", levelEnable, 0);
        chk("async_title", titleScreenEn, 1);
        chk("async_state", stateCode, S_TITLE);
        resetN = 1;
        step();

`ifdef GAME_FLOW_PAUSE_EN
        // Pause freezes the second count
        do_reset();
        go_play();
        repeat (4) step();
        pauseKey = 1;
        repeat (3) step();
        pauseKey = 0;
        chk("pause_state", stateCode, S_PAUSE);
        chk("pause_le", levelEnable, 1);
        pulse_seen = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (oneSecPulse) pulse_seen++;
        end
        chk("pause_no_pulse", pulse_seen, 0);
        chk("pause_le_hold", levelEnable, 1);
        pauseKey = 1;
        repeat (3) step();
        pauseKey = 0;
        chk("unpause_state", stateCode, S_PLAY);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("unpause_pulse%0d", k), oneSecPulse, (k == 3) ? 1 : 0);
        end
`else
        pulse_seen = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer, directly upstream of the level controller.
- Drives the level controller's enable, cycleLevel and oneSecPulse inputs.
- Consumes its stageEnded, stageFailed and lastLevelEnded outputs.
- Selects which full-screen overlay (title, result, game-over, win) the video mux shows, and aligns level start to a frame boundary.

Parameters:
- CLK_FREQ_HZ, 25_000_000: clock cycles per second; sets the oneSecPulse period.
- RESULT_HOLD_SEC, 3: seconds the result screen is held before the next level arms.
- SYNC_STAGES, 2: flip-flop synchronizer depth on key inputs.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startKey  in  1  raw push button, level, active-high, asynchronous to clk
- startOfFrame  in  1  one-cycle pulse at frame start
- stageEnded  in  1  one-cycle pulse from the level controller: time expired
- stageFailed  in  1  level controller: level failed
- lastLevelEnded  in  1  level controller: final level complete (sampled together with stageEnded)
- levelEnable  out  1  enable to the level controller
- cycleLevel  out  1  one-cycle pulse: advance level index
- oneSecPulse  out  1  one-cycle tick per second, only while PLAY
- titleScreenEn  out  1  overlay select
- resultScreenEn  out  1  overlay select
- gameOverScreenEn  out  1  overlay select
- winScreenEn  out  1  overlay select
- stateCode  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset (async, resetN low):
  - State = TITLE; all counters 0; synchronizers cleared.
  - titleScreenEn = 1; every other output = 0; stateCode = TITLE.
- All outputs are registered and decoded from the state register. No combinational paths from inputs to outputs.
- Key handling:
  - startKey passes through a SYNC_STAGES synchronizer.
  - keyRise = synced & ~synced_d, a one-cycle pulse.
  - A held key yields exactly one keyRise.
- States and transitions (at most one transition per cycle):
  - TITLE: keyRise -> ARM.
  - ARM: waits for startOfFrame -> PLAY. levelEnable = 0 throughout ARM, so the level controller always sees a fresh rising edge of levelEnable.
  - PLAY: levelEnable = 1. Priority when inputs coincide:
    - stageFailed -> GAME_OVER (highest).
    - stageEnded && lastLevelEnded -> WIN.
    - stageEnded -> RESULT, with cycleLevel = 1 for exactly the cycle after the stageEnded sample.
    - keyRise is ignored in PLAY.
  - RESULT: holdCnt increments on each oneSecTick. Leave to ARM when holdCnt == RESULT_HOLD_SEC-1 and a tick occurs, or on keyRise (skip). holdCnt clears on entry.
  - GAME_OVER, WIN: keyRise -> TITLE.
- Exit timing: levelEnable falls in the cycle after the exit condition (one-cycle latency).
- oneSecPulse and tick counter:
  - Counter width $clog2(CLK_FREQ_HZ). Counts 0..CLK_FREQ_HZ-1 and wraps.
  - oneSecTick fires at the terminal count.
  - Counter forced to 0 on entry to PLAY and on entry to RESULT, so the first tick comes exactly CLK_FREQ_HZ cycles after entry.
  - oneSecPulse = oneSecTick gated by PLAY. The internal tick also runs in RESULT for holdCnt.
- Overlay selects:
  - titleScreenEn in TITLE.
  - resultScreenEn in RESULT and ARM-from-RESULT.
  - gameOverScreenEn in GAME_OVER.
  - winScreenEn in WIN.
  - At most one select is high at any time.
- Reset mid-PLAY returns to TITLE immediately, with levelEnable low asynchronously.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- When defined:
  - Adds input pauseKey (raw, synchronized like startKey) and a PAUSE state.
  - pauseRise in PLAY -> PAUSE. pauseRise in PAUSE -> PLAY.
  - In PAUSE: levelEnable stays 1 (no reload edge); the tick counter freezes, holding its value; oneSecPulse = 0; stageEnded/stageFailed are ignored; stateCode = PAUSE.
- When undefined: no pauseKey port, no PAUSE state; behaviour exactly as above.

Decomposition:
- Shared package game_flow_pkg holds:
  - typedef enum logic [2:0] game_state_t: TITLE=0, ARM=1, PLAY=2, RESULT=3, GAME_OVER=4, WIN=5, PAUSE=6.
  - Default CLK_FREQ_HZ constant.
- One sub-module: tick_gen, with params CLK_FREQ_HZ; ports clk, resetN, clear, freeze; output tick. Reused for other second-based timers.

Test Plan (sim with CLK_FREQ_HZ=10, RESULT_HOLD_SEC=3):
- Reset, hold startKey 20 cycles, then startOfFrame at cycle 30:
  - Exactly one TITLE->ARM transition.
  - levelEnable rises the cycle after startOfFrame, not before.
- In PLAY, run 35 cycles:
  - oneSecPulse at cycles 10, 20, 30 after PLAY entry.
  - Each pulse is one cycle wide.
- In PLAY, pulse stageEnded with lastLevelEnded=0:
  - cycleLevel = 1 for one cycle; levelEnable = 0 the next cycle.
  - resultScreenEn = 1; ARM reached after 30 cycles; PLAY resumes at the next startOfFrame.
- Same cycle stageEnded=1, stageFailed=1, lastLevelEnded=1:
  - State GAME_OVER; cycleLevel stays 0; winScreenEn stays 0.
- stageEnded with lastLevelEnded=1:
  - WIN.
  - keyRise returns to TITLE; second keyRise re-arms.
- Assert resetN low mid-PLAY at an arbitrary cycle:
  - levelEnable = 0 and titleScreenEn = 1 without waiting for a clock edge.
  - With GAME_FLOW_PAUSE_EN, pause for 25 cycles: no oneSecPulse during pause, and the next pulse comes exactly the remaining count after unpause.
